// File: rtl/car_alarm_siren_controller_if.sv
// Siren controller bus: raw alarm condition in, buzzer/status out.
// SilenceButton is present only when SIREN_SILENCE_EN is defined.
interface car_alarm_siren_controller_if #(
    parameter int MAX_BEEPS = 3
);
    localparam int W = $clog2(MAX_BEEPS + 1);

    logic         CarAlarmSignal;
`ifdef SIREN_SILENCE_EN
    logic         SilenceButton;
`endif
    logic         BuzzerOut;
    logic         AlarmActive;
    logic [W-1:0] BeepCount;

    // Master: the alarm condition stage / driver controls
    modport master (
        output CarAlarmSignal,
`ifdef SIREN_SILENCE_EN
        output SilenceButton,
`endif
        input  BuzzerOut,
        input  AlarmActive,
        input  BeepCount
    );

    // Slave: the siren controller
    modport slave (
        input  CarAlarmSignal,
`ifdef SIREN_SILENCE_EN
        input  SilenceButton,
`endif
        output BuzzerOut,
        output AlarmActive,
        output BeepCount
    );
endinterface

// File: rtl/car_alarm_siren_controller.sv
// Car alarm siren controller: debounces CarAlarmSignal, then plays a latched
// pattern of MAX_BEEPS on/off pulses followed by a re-trigger holdoff.
// Optional feature macro: SIREN_SILENCE_EN (adds SilenceButton; silence
// aborts the beep pattern into HOLDOFF, or drops qualification back to IDLE).
module car_alarm_siren_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int BEEP_ON_CYCLES  = 8,
    parameter int BEEP_OFF_CYCLES = 8,
    parameter int MAX_BEEPS       = 3,
    parameter int HOLDOFF_CYCLES  = 16
) (
    input  logic                         Clock,
    input  logic                         Reset,
    car_alarm_siren_controller_if.slave  sirenBus
);
    localparam int W = $clog2(MAX_BEEPS + 1);

    // One shared timer serves qualification, beep on/off and holdoff; size it
    // for the largest terminal count among them.
    localparam int MAX_A  = (DEBOUNCE_CYCLES > BEEP_ON_CYCLES) ? DEBOUNCE_CYCLES : BEEP_ON_CYCLES;
    localparam int MAX_B  = (BEEP_OFF_CYCLES > HOLDOFF_CYCLES) ? BEEP_OFF_CYCLES : HOLDOFF_CYCLES;
    localparam int MAX_T  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TW     = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    localparam logic [TW-1:0] QUAL_LAST = TW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] ON_LAST   = TW'(BEEP_ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LAST  = TW'(BEEP_OFF_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLDOFF_CYCLES - 1);
    localparam logic [W-1:0]  BEEP_LAST = W'(MAX_BEEPS);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        QUALIFY  = 3'd1,
        BEEP_ON  = 3'd2,
        BEEP_OFF = 3'd3,
        HOLDOFF  = 3'd4
    } sirenState_t;

    sirenState_t   state_r;
    logic [TW-1:0] timer_r;
    logic [W-1:0]  beepCnt_r;
    logic          silence_s;

`ifdef SIREN_SILENCE_EN
    assign silence_s = sirenBus.SilenceButton;
`else
    assign silence_s = 1'b0;
`endif

    // Outputs decode straight from the state register so they change exactly
    // at the edge that changes state.
    assign sirenBus.BuzzerOut   = (state_r == BEEP_ON);
    assign sirenBus.AlarmActive = (state_r == BEEP_ON) || (state_r == BEEP_OFF);
    assign sirenBus.BeepCount   = beepCnt_r;

    // Siren sequencing FSM with its timer and beep counter.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r   <= IDLE;
            timer_r   <= {TW{1'b0}};
            beepCnt_r <= {W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    beepCnt_r <= {W{1'b0}};
                    timer_r   <= {TW{1'b0}};
                    if (sirenBus.CarAlarmSignal) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_r <= BEEP_ON;
                        end else begin
                            state_r <= QUALIFY;
                            timer_r <= TW'(1);
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end

                QUALIFY: begin
                    if (silence_s || !sirenBus.CarAlarmSignal) begin
                        state_r <= IDLE;
                        timer_r <= {TW{1'b0}};
                    end else if (timer_r == QUAL_LAST) begin
                        state_r <= BEEP_ON;
                        timer_r <= {TW{1'b0}};
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end

                // The input is deliberately not looked at while beeping: the
                // pattern is latched once it starts.
                BEEP_ON: begin
                    if (silence_s) begin
                        state_r <= HOLDOFF;
                        timer_r <= {TW{1'b0}};
                    end else if (timer_r == ON_LAST) begin
                        state_r   <= BEEP_OFF;
                        timer_r   <= {TW{1'b0}};
                        beepCnt_r <= beepCnt_r + W'(1);
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end

                BEEP_OFF: begin
                    if (silence_s) begin
                        state_r <= HOLDOFF;
                        timer_r <= {TW{1'b0}};
                    end else if (timer_r == OFF_LAST) begin
                        timer_r <= {TW{1'b0}};
                        if (beepCnt_r == BEEP_LAST) begin
                            state_r <= HOLDOFF;
                        end else begin
                            state_r <= BEEP_ON;
                        end
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end

                // Timer saturates; leaving needs both the minimum time and a
                // low sample, so a persistent condition cannot re-trigger.
                HOLDOFF: begin
                    if (timer_r == HOLD_LAST) begin
                        if (!sirenBus.CarAlarmSignal) begin
                            state_r   <= IDLE;
                            timer_r   <= {TW{1'b0}};
                            beepCnt_r <= {W{1'b0}};
                        end else begin
                            state_r <= HOLDOFF;
                        end
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end

                default: begin
                    state_r   <= IDLE;
                    timer_r   <= {TW{1'b0}};
                    beepCnt_r <= {W{1'b0}};
                end
            endcase
        end
    end
endmodule

// File: tb/tb_car_alarm_siren_controller.sv
// Directed testbench for car_alarm_siren_controller (default parameters).
// Observed vector per cycle: {BuzzerOut, AlarmActive, BeepCount[1:0]}.
module tb_car_alarm_siren_controller;
    logic Clock;
    logic Reset;
    int   nCmp;
    int   nBad;

    car_alarm_siren_controller_if #(.MAX_BEEPS(3)) sirenBus ();

    car_alarm_siren_controller dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .sirenBus (sirenBus)
    );

    // Free-running clock, 10 time units period.
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    function automatic logic [3:0] obs();
        return {sirenBus.BuzzerOut, sirenBus.AlarmActive, sirenBus.BeepCount};
    endfunction

    function automatic logic [3:0] mk(input logic buz, input logic act, input int cnt);
        logic [1:0] c;
        c = 2'(cnt);
        return {buz, act, c};
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        tick();
        nCmp++;
        if (obs() !== 4'b0000) begin
            nBad++;
            $display("FAIL reset_state: got %b expected %b", obs(), 4'b0000);
        end
        Reset = 1'b0;
        tick();
        nCmp++;
        if (obs() !== 4'b0000) begin
            nBad++;
            $display("FAIL reset_release_idle: got %b expected %b", obs(), 4'b0000);
        end
    endtask

    // Three high samples are one short of qualification.
    task automatic test_glitch();
        sirenBus.CarAlarmSignal = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            nCmp++;
            if (obs() !== 4'b0000) begin
                nBad++;
                $display("FAIL glitch_high_%0d: got %b expected %b", k, obs(), 4'b0000);
            end
        end
        sirenBus.CarAlarmSignal = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            nCmp++;
            if (obs() !== 4'b0000) begin
                nBad++;
                $display("FAIL glitch_low_%0d: got %b expected %b", k, obs(), 4'b0000);
            end
        end
    endtask

    // Full pattern with the input released right after qualification.
    task automatic test_normal();
        sirenBus.CarAlarmSignal = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            nCmp++;
            if (obs() !== mk(k == 4, k == 4, 0)) begin
                nBad++;
                $display("FAIL normal_qual_%0d: got %b expected %b", k, obs(), mk(k == 4, k == 4, 0));
            end
        end
        sirenBus.CarAlarmSignal = 1'b0;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 8; i++) begin
                nCmp++;
                if (obs() !== mk(1'b1, 1'b1, b)) begin
                    nBad++;
                    $display("FAIL normal_on_b%0d_c%0d: got %b expected %b", b, i, obs(), mk(1'b1, 1'b1, b));
                end
                tick();
            end
            for (int i = 0; i < 8; i++) begin
                nCmp++;
                if (obs() !== mk(1'b0, 1'b1, b + 1)) begin
                    nBad++;
                    $display("FAIL normal_off_b%0d_c%0d: got %b expected %b", b, i, obs(), mk(1'b0, 1'b1, b + 1));
                end
                tick();
            end
        end
        for (int i = 0; i < 16; i++) begin
            nCmp++;
            if (obs() !== mk(1'b0, 1'b0, 3)) begin
                nBad++;
                $display("FAIL normal_holdoff_c%0d: got %b expected %b", i, obs(), mk(1'b0, 1'b0, 3));
            end
            tick();
        end
        nCmp++;
        if (obs() !== 4'b0000) begin
            nBad++;
            $display("FAIL normal_back_idle: got %b expected %b", obs(), 4'b0000);
        end
    endtask

    // Input held high (with a one-cycle dropout in beep 1's off phase):
    // pattern unaffected, HOLDOFF persists, then re-arm and re-trigger.
    task automatic test_hold_high();
        sirenBus.CarAlarmSignal = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            nCmp++;
            if (obs() !== mk(k == 4, k == 4, 0)) begin
                nBad++;
                $display("FAIL hold_qual_%0d: got %b expected %b", k, obs(), mk(k == 4, k == 4, 0));
            end
        end
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 8; i++) begin
                nCmp++;
                if (obs() !== mk(1'b1, 1'b1, b)) begin
                    nBad++;
                    $display("FAIL hold_on_b%0d_c%0d: got %b expected %b", b, i, obs(), mk(1'b1, 1'b1, b));
                end
                tick();
            end
            for (int i = 0; i < 8; i++) begin
                nCmp++;
                if (obs() !== mk(1'b0, 1'b1, b + 1)) begin
                    nBad++;
                    $display("FAIL hold_off_b%0d_c%0d: got %b expected %b", b, i, obs(), mk(1'b0, 1'b1, b + 1));
                end
                sirenBus.CarAlarmSignal = (b == 0 && i == 2) ? 1'b0 : 1'b1;
                tick();
            end
        end
        sirenBus.CarAlarmSignal = 1'b1;
        for (int i = 0; i < 40; i++) begin
            nCmp++;
            if (obs() !== mk(1'b0, 1'b0, 3)) begin
                nBad++;
                $display("FAIL hold_holdoff_c%0d: got %b expected %b", i, obs(), mk(1'b0, 1'b0, 3));
            end
            tick();
        end
        sirenBus.CarAlarmSignal = 1'b0;
        tick();
        nCmp++;
        if (obs() !== 4'b0000) begin
            nBad++;
            $display("FAIL hold_release_idle: got %b expected %b", obs(), 4'b0000);
        end
        sirenBus.CarAlarmSignal = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            nCmp++;
            if (obs() !== mk(k == 4, k == 4, 0)) begin
                nBad++;
                $display("FAIL hold_retrigger_%0d: got %b expected %b", k, obs(), mk(k == 4, k == 4, 0));
            end
        end
        sirenBus.CarAlarmSignal = 1'b0;
        repeat (64) tick();
        nCmp++;
        if (obs() !== 4'b0000) begin
            nBad++;
            $display("FAIL hold_second_event_idle: got %b expected %b", obs(), 4'b0000);
        end
    endtask

    // Reset during the 2nd beep's on phase forces the idle state at that edge.
    task automatic test_reset_mid();
        sirenBus.CarAlarmSignal = 1'b1;
        repeat (4) tick();
        sirenBus.CarAlarmSignal = 1'b0;
        repeat (18) tick();
        nCmp++;
        if (obs() !== mk(1'b1, 1'b1, 1)) begin
            nBad++;
            $display("FAIL rstmid_pre: got %b expected %b", obs(), mk(1'b1, 1'b1, 1));
        end
        Reset = 1'b1;
        tick();
        nCmp++;
        if (obs() !== 4'b0000) begin
            nBad++;
            $display("FAIL rstmid_edge: got %b expected %b", obs(), 4'b0000);
        end
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            nCmp++;
            if (obs() !== 4'b0000) begin
                nBad++;
                $display("FAIL rstmid_after_%0d: got %b expected %b", i, obs(), 4'b0000);
            end
        end
    endtask

    // Silence in cycle 3 of beep 2 (when the feature is built in).
    task automatic test_silence();
        sirenBus.CarAlarmSignal = 1'b1;
        repeat (4) tick();
        sirenBus.CarAlarmSignal = 1'b0;
        repeat (18) tick();
        nCmp++;
        if (obs() !== mk(1'b1, 1'b1, 1)) begin
            nBad++;
            $display("FAIL silence_pre: got %b expected %b", obs(), mk(1'b1, 1'b1, 1));
        end
`ifdef SIREN_SILENCE_EN
        sirenBus.SilenceButton = 1'b1;
        tick();
        sirenBus.SilenceButton = 1'b0;
        for (int i = 0; i < 16; i++) begin
            nCmp++;
            if (obs() !== mk(1'b0, 1'b0, 1)) begin
                nBad++;
                $display("FAIL silence_holdoff_c%0d: got %b expected %b", i, obs(), mk(1'b0, 1'b0, 1));
            end
            tick();
        end
`else
        tick();
        nCmp++;
        if (obs() !== mk(1'b1, 1'b1, 1)) begin
            nBad++;
            $display("FAIL nosilence_continue: got %b expected %b", obs(), mk(1'b1, 1'b1, 1));
        end
        repeat (29) tick();
        nCmp++;
        if (obs() !== mk(1'b0, 1'b0, 3)) begin
            nBad++;
            $display("FAIL nosilence_complete: got %b expected %b", obs(), mk(1'b0, 1'b0, 3));
        end
        repeat (16) tick();
`endif
        nCmp++;
        if (obs() !== 4'b0000) begin
            nBad++;
            $display("FAIL silence_back_idle: got %b expected %b", obs(), 4'b0000);
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        nCmp = 0;
        nBad = 0;
        Reset = 1'b1;
        sirenBus.CarAlarmSignal = 1'b0;
`ifdef SIREN_SILENCE_EN
        sirenBus.SilenceButton = 1'b0;
`endif
        #1;
        test_reset();
        test_glitch();
        test_normal();
        test_hold_high();
        test_reset_mid();
        test_silence();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
